// File: rtl/jvm_bytecode_fetch.sv
// Bytecode fetch/prefetch stage: streams instruction RAM bytes through a
// small FIFO to the translator, with start, redirect and halt handling.
module jvm_bytecode_fetch #(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    input  logic              halt,
    input  logic              take,
    output logic              iram_en,
    output logic [ADDR_W-1:0] iram_adr,
    input  logic [7:0]        iram_rdata,
    output logic [7:0]        iram_data,
    output logic [ADDR_W-1:0] head_pc,
    output logic              waiting,
    output logic              running
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] fetch_adr_q, fetch_adr_d;
    logic [ADDR_W-1:0] head_pc_q, head_pc_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              inflight_q, inflight_d;
    logic              bubble_q, bubble_d;
    logic [7:0]        mem_q [DEPTH];

    logic              wr_en;
    logic              pop;
    logic              do_take;
    logic [CW:0]       occupancy;
    logic [ADDR_W-1:0] new_adr;

    assign running   = (state_q == RUN);
    assign waiting   = (count_q == '0) || (state_q == IDLE);
    assign iram_adr  = fetch_adr_q;
    assign head_pc   = head_pc_q;
    assign iram_data = waiting ? 8'h00 : mem_q[rd_ptr_q];
    assign do_take   = take && !waiting;

    // Credit check uses only registered state, so take never reaches iram_en.
    assign occupancy = {1'b0, count_q} + (CW + 1)'(inflight_q);
    assign iram_en   = running && !bubble_q &&
                       (occupancy < (CW + 1)'(DEPTH));

    always_comb begin
        state_d     = state_q;
        fetch_adr_d = fetch_adr_q;
        head_pc_d   = head_pc_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        inflight_d  = 1'b0;
        bubble_d    = 1'b0;
        wr_en       = 1'b0;
        pop         = 1'b0;
        new_adr     = start ? start_addr : redirect_addr;

        if (halt) begin
            state_d  = IDLE;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else if (start || (redirect && running)) begin
            state_d     = RUN;
            fetch_adr_d = new_adr;
            head_pc_d   = new_adr;
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            count_d     = '0;
            bubble_d    = running;
        end else begin
            if (iram_en) begin
                fetch_adr_d = fetch_adr_q + ADDR_W'(1);
                inflight_d  = 1'b1;
            end
            wr_en = inflight_q;
            pop   = do_take;
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d  = rd_ptr_q + PW'(1);
                head_pc_d = head_pc_q + ADDR_W'(1);
            end
            count_d = count_q + CW'(wr_en) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            fetch_adr_q <= '0;
            head_pc_q   <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            inflight_q  <= 1'b0;
            bubble_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_adr_q <= fetch_adr_d;
            head_pc_q   <= head_pc_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            inflight_q  <= inflight_d;
            bubble_q    <= bubble_d;
            if (wr_en) begin
                mem_q[wr_ptr_q] <= iram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_jvm_bytecode_fetch.sv
// Scoreboard bench for jvm_bytecode_fetch: stimulus queues expected
// bytes, a negedge monitor checks each one as it is consumed.
module tb_jvm_bytecode_fetch;

    typedef struct packed {
        logic [7:0]  d;
        logic [15:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] start_addr = '0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_addr = '0;
    logic        halt = 1'b0;
    logic        take = 1'b0;
    logic        iram_en;
    logic [15:0] iram_adr;
    logic [7:0]  iram_rdata = 8'hEE;
    logic [7:0]  iram_data;
    logic [15:0] head_pc;
    logic        waiting;
    logic        running;

    int total = 0;
    int bad = 0;
    exp_t exp_q[$];
    logic [15:0] issue_log[$];

    jvm_bytecode_fetch #(.ADDR_W(16), .DEPTH(4)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .start_addr(start_addr),
        .redirect(redirect),
        .redirect_addr(redirect_addr),
        .halt(halt),
        .take(take),
        .iram_en(iram_en),
        .iram_adr(iram_adr),
        .iram_rdata(iram_rdata),
        .iram_data(iram_data),
        .head_pc(head_pc),
        .waiting(waiting),
        .running(running)
    );

    always #5 clk = ~clk;

    // RAM model: RAM[i] = i[7:0], one-cycle read latency.
    always @(posedge clk) begin
        if (iram_en) iram_rdata <= iram_adr[7:0];
        else         iram_rdata <= 8'hEE;
    end

    always @(negedge clk) begin
        if (iram_en) issue_log.push_back(iram_adr);
    end

    always @(negedge clk) begin
        exp_t e;
        if (take && !waiting) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL extra_byte: got data=%02h pc=%04h want none",
                         iram_data, head_pc);
            end else begin
                e = exp_q.pop_front();
                if (iram_data !== e.d || head_pc !== e.pc) begin
                    bad++;
                    $display("FAIL byte: got data=%02h pc=%04h want data=%02h pc=%04h",
                             iram_data, head_pc, e.d, e.pc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_run(input logic [15:0] a, input int n);
        logic [15:0] p;
        for (int i = 0; i < n; i++) begin
            p = a + 16'(i);
            exp_q.push_back({p[7:0], p});
        end
    endtask

    task automatic wait_empty(input int max, output int n);
        n = 0;
        while (exp_q.size() != 0 && n < max) begin
            cyc();
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: got %0d left want 0", exp_q.size());
            exp_q.delete();
        end
        take = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_en"}, 32'(iram_en), 32'd0);
        chk({tag, "_adr"}, 32'(iram_adr), 32'd0);
        chk({tag, "_data"}, 32'(iram_data), 32'd0);
        chk({tag, "_pc"}, 32'(head_pc), 32'd0);
        chk({tag, "_wait"}, 32'(waiting), 32'd1);
        chk({tag, "_run"}, 32'(running), 32'd0);
    endtask

    task automatic pulse_halt();
        halt = 1'b1;
        cyc();
        halt = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (2) cyc();
        @(negedge clk);
        chk_reset_vals("rst");
        cyc();
        reset = 1'b1;

        // Sustained streaming from 0x0010.
        cyc();
        start = 1'b1;
        start_addr = 16'h0010;
        take = 1'b1;
        push_run(16'h0010, 16);
        cyc();
        start = 1'b0;
        @(negedge clk);
        chk("start_en", 32'(iram_en), 32'd1);
        chk("start_adr", 32'(iram_adr), 32'h10);
        chk("start_wait0", 32'(waiting), 32'd1);
        cyc();
        @(negedge clk);
        chk("start_wait1", 32'(waiting), 32'd1);
        cyc();
        @(negedge clk);
        chk("start_wait2", 32'(waiting), 32'd0);
        wait_empty(40, n);
        chk("throughput", 32'(n), 32'd16);

        // Halt mid-run.
        pulse_halt();
        @(negedge clk);
        chk("halt_run", 32'(running), 32'd0);
        chk("halt_wait", 32'(waiting), 32'd1);
        chk("halt_en", 32'(iram_en), 32'd0);
        chk("halt_data", 32'(iram_data), 32'd0);

        // Fill without take, then one take frees one credit.
        cyc();
        start = 1'b1;
        start_addr = 16'h0040;
        issue_log.delete();
        cyc();
        start = 1'b0;
        repeat (8) cyc();
        chk("fill_issues", 32'(issue_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < issue_log.size())
                chk("fill_adr", 32'(issue_log[i]), 32'h40 + 32'(i));
        end
        issue_log.delete();
        push_run(16'h0040, 1);
        take = 1'b1;
        cyc();
        take = 1'b0;
        repeat (5) cyc();
        chk("credit_issues", 32'(issue_log.size()), 32'd1);
        if (issue_log.size() > 0)
            chk("credit_adr", 32'(issue_log[0]), 32'h44);
        @(negedge clk);
        chk("credit_pc", 32'(head_pc), 32'h41);
        chk("credit_data", 32'(iram_data), 32'h41);
        cyc();
        pulse_halt();

        // Redirect with 3 buffered bytes and 1 in flight.
        start = 1'b1;
        start_addr = 16'h0020;
        cyc();
        start = 1'b0;
        repeat (4) cyc();
        redirect = 1'b1;
        redirect_addr = 16'h0200;
        cyc();
        redirect = 1'b0;
        push_run(16'h0200, 3);
        issue_log.delete();
        @(negedge clk);
        chk("redir_wait0", 32'(waiting), 32'd1);
        chk("redir_bubble", 32'(iram_en), 32'd0);
        cyc();
        @(negedge clk);
        chk("redir_wait1", 32'(waiting), 32'd1);
        chk("redir_adr", 32'(iram_adr), 32'h200);
        cyc();
        @(negedge clk);
        chk("redir_wait2", 32'(waiting), 32'd1);
        take = 1'b1;
        cyc();
        @(negedge clk);
        chk("redir_wait3", 32'(waiting), 32'd0);
        wait_empty(20, n);
        pulse_halt();

        // Address wrap.
        start = 1'b1;
        start_addr = 16'hFFFE;
        take = 1'b1;
        push_run(16'hFFFE, 4);
        cyc();
        start = 1'b0;
        wait_empty(20, n);
        pulse_halt();

        // Reset during sustained fetch.
        start = 1'b1;
        start_addr = 16'h0080;
        take = 1'b1;
        push_run(16'h0080, 3);
        cyc();
        start = 1'b0;
        wait_empty(20, n);
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        @(negedge clk);
        chk_reset_vals("mid_rst");
        cyc();
        start = 1'b1;
        start_addr = 16'h0090;
        cyc();
        start = 1'b0;
        @(negedge clk);
        chk("rst_run", 32'(running), 32'd1);
        cyc();
        @(negedge clk);
        chk("rst_wait1", 32'(waiting), 32'd1);
        cyc();
        @(negedge clk);
        chk("rst_wait2", 32'(waiting), 32'd0);
        chk("rst_data", 32'(iram_data), 32'h90);
        chk("rst_pc", 32'(head_pc), 32'h90);
        cyc();
        pulse_halt();

        chk("leftover", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
